// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT sample store.
package fft_pkg;

  // Phase codes presented on the phase output. Code 3 is illegal and recovers to LOAD.
  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } phase_e;

  // Tag carried alongside each RAM read so the returning data is routed correctly.
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_A    = 2'd1,
    RD_B    = 2'd2,
    RD_DOUT = 2'd3
  } rd_kind_e;

  // Reverse the low 'size' bits of v. The result occupies bits [size-1:0].
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int size);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < size; i++) begin
      r = {r[30:0], v[i]};
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_sample_ram_if.sv
// Bus between the FFT sample store and its controller / producer / consumer.
// Handshake semantics: din_valid is a strobe that is only honoured while
// din_ready is high; en_rd/en_wr are one-cycle command strobes with no
// back-pressure; op_valid and dout_valid are one-cycle result strobes that
// the receiver must accept unconditionally (no ready back to the store).
interface fft_sample_ram_if #(
  parameter int BW   = 29,
  parameter int SIZE = 4
);
  logic              din_valid;
  logic [BW-1:0]     din_re;
  logic [BW-1:0]     din_im;
  logic              din_ready;
  logic              flag_start_FFT;
  logic              en_rd;
  logic [SIZE:0]     rd_ptr;
  logic              en_wr;
  logic [SIZE:0]     wr_ptr;
  logic [BW-1:0]     wr_re;
  logic [BW-1:0]     wr_im;
  logic              finish_FFT;
  logic              done_o;
  logic              op_valid;
  logic [BW-1:0]     op_a_re;
  logic [BW-1:0]     op_a_im;
  logic [BW-1:0]     op_b_re;
  logic [BW-1:0]     op_b_im;
  logic              dout_valid;
  logic [BW-1:0]     dout_re;
  logic [BW-1:0]     dout_im;
  logic [1:0]        phase;

  modport slave (
    input  din_valid, din_re, din_im, en_rd, rd_ptr, en_wr, wr_ptr,
           wr_re, wr_im, finish_FFT, done_o,
    output din_ready, flag_start_FFT, op_valid, op_a_re, op_a_im,
           op_b_re, op_b_im, dout_valid, dout_re, dout_im, phase
  );

  modport master (
    output din_valid, din_re, din_im, en_rd, rd_ptr, en_wr, wr_ptr,
           wr_re, wr_im, finish_FFT, done_o,
    input  din_ready, flag_start_FFT, op_valid, op_a_re, op_a_im,
           op_b_re, op_b_im, dout_valid, dout_re, dout_im, phase
  );
endinterface

// File: rtl/fft_dp_ram.sv
// 1R1W synchronous RAM, read-first: a same-address read and write in one
// cycle returns the data stored before the write.
module fft_dp_ram #(
  parameter int DW    = 58,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write and registered read share one edge; non-blocking gives read-first.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/fft_sample_ram.sv
// Sample store for the in-place FFT: bit-reversed load, paired butterfly
// reads with write-back during compute, single-sample streaming on unload.
module fft_sample_ram
  import fft_pkg::*;
#(
  parameter int bit_width = 29,
  parameter int N         = 16,
  parameter int SIZE      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fft_sample_ram_if.slave   bus
);
  localparam int DW = 2 * bit_width;

  phase_e              state_q, state_d;
  logic [SIZE-1:0]     cnt_q, cnt_d;
  logic                toggle_q, toggle_d;
  logic                start_q, start_d;
  rd_kind_e            rd_kind_q, rd_kind_d;
  logic                rd_oob_q, rd_oob_d;
  logic [bit_width-1:0] op_a_re_q, op_a_im_q, op_b_re_q, op_b_im_q;

  logic                ram_we;
  logic [SIZE-1:0]     ram_waddr;
  logic [DW-1:0]       ram_wdata;
  logic                ram_re;
  logic [SIZE-1:0]     ram_raddr;
  logic [DW-1:0]       ram_rdata;
  logic [DW-1:0]       rd_data;

  fft_dp_ram #(.DW(DW), .DEPTH(N), .AW(SIZE)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Next-state, RAM port steering and read tagging per phase.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    toggle_d  = toggle_q;
    start_d   = 1'b0;
    rd_kind_d = RD_NONE;
    rd_oob_d  = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = bus.wr_ptr[SIZE-1:0];
    ram_wdata = {bus.wr_re, bus.wr_im};
    ram_re    = 1'b0;
    ram_raddr = bus.rd_ptr[SIZE-1:0];
    case (state_q)
      LOAD: begin
        // Controller strobes are ignored here, including a stale en_rd.
        if (bus.din_valid) begin
          ram_we    = 1'b1;
          ram_waddr = SIZE'(bitrev(32'(cnt_q), SIZE));
          ram_wdata = {bus.din_re, bus.din_im};
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == SIZE'(N - 1)) begin
            cnt_d    = '0;
            start_d  = 1'b1;
            toggle_d = 1'b0;
            state_d  = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        ram_we = bus.en_wr & ~bus.wr_ptr[SIZE];
        if (bus.en_rd) begin
          ram_re    = 1'b1;
          rd_oob_d  = bus.rd_ptr[SIZE];
          rd_kind_d = toggle_q ? RD_B : RD_A;
          toggle_d  = ~toggle_q;
        end
        // A half-issued pair is dropped by clearing the toggle; a pair whose
        // second read is in flight still completes through its tag.
        if (bus.finish_FFT) begin
          toggle_d = 1'b0;
          state_d  = UNLOAD;
        end
      end
      UNLOAD: begin
        ram_we = bus.en_wr & ~bus.wr_ptr[SIZE];
        if (bus.en_rd) begin
          ram_re    = 1'b1;
          rd_oob_d  = bus.rd_ptr[SIZE];
          rd_kind_d = RD_DOUT;
        end
        if (bus.done_o) begin
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      default: begin
        cnt_d    = '0;
        toggle_d = 1'b0;
        state_d  = LOAD;
      end
    endcase
  end

  // Control state; reset squashes any read still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      cnt_q     <= '0;
      toggle_q  <= 1'b0;
      start_q   <= 1'b0;
      rd_kind_q <= RD_NONE;
      rd_oob_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      toggle_q  <= toggle_d;
      start_q   <= start_d;
      rd_kind_q <= rd_kind_d;
      rd_oob_q  <= rd_oob_d;
    end
  end

  // Out-of-range reads return zero regardless of RAM contents.
  assign rd_data = rd_oob_q ? '0 : ram_rdata;

  // Operand hold registers: A captured when its data returns, B alongside op_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_re_q <= '0;
      op_a_im_q <= '0;
      op_b_re_q <= '0;
      op_b_im_q <= '0;
    end else begin
      if (rd_kind_q == RD_A) begin
        op_a_re_q <= rd_data[DW-1:bit_width];
        op_a_im_q <= rd_data[bit_width-1:0];
      end
      if (rd_kind_q == RD_B) begin
        op_b_re_q <= rd_data[DW-1:bit_width];
        op_b_im_q <= rd_data[bit_width-1:0];
      end
    end
  end

  // B is forwarded straight from the RAM in its valid cycle so the pair
  // appears two cycles after a back-to-back first read.
  assign bus.op_valid       = (rd_kind_q == RD_B);
  assign bus.op_a_re        = op_a_re_q;
  assign bus.op_a_im        = op_a_im_q;
  assign bus.op_b_re        = bus.op_valid ? rd_data[DW-1:bit_width] : op_b_re_q;
  assign bus.op_b_im        = bus.op_valid ? rd_data[bit_width-1:0]  : op_b_im_q;
  assign bus.dout_valid     = (rd_kind_q == RD_DOUT);
  assign bus.dout_re        = bus.dout_valid ? rd_data[DW-1:bit_width] : '0;
  assign bus.dout_im        = bus.dout_valid ? rd_data[bit_width-1:0]  : '0;
  assign bus.din_ready      = (state_q == LOAD);
  assign bus.flag_start_FFT = start_q;
  assign bus.phase          = state_q;
endmodule

// File: tb/tb_fft_sample_ram.sv
// Bench for fft_sample_ram: directed vectors, scoreboard queues checked by a
// monitor on the falling edge.
module tb_fft_sample_ram;
  localparam int BW   = 29;
  localparam int N    = 16;
  localparam int SIZE = 4;
  localparam int DW   = 2 * BW;
  localparam int OPW  = 4 * BW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fft_sample_ram_if #(.BW(BW), .SIZE(SIZE)) bus ();

  fft_sample_ram #(.bit_width(BW), .N(N), .SIZE(SIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [DW-1:0]  mem_m [N];
  logic [OPW-1:0] exp_op_q[$];
  int             exp_op_cyc_q[$];
  logic [DW-1:0]  exp_dout_q[$];
  int             exp_dout_cyc_q[$];

  function automatic int brev(input int v);
    int r;
    r = 0;
    for (int i = 0; i < SIZE; i++) if (v[i]) r = r | (1 << (SIZE - 1 - i));
    return r;
  endfunction

  task automatic check(input string name, input logic [OPW-1:0] act, input logic [OPW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.din_valid  = 1'b0;
    bus.din_re     = '0;
    bus.din_im     = '0;
    bus.en_rd      = 1'b0;
    bus.rd_ptr     = '0;
    bus.en_wr      = 1'b0;
    bus.wr_ptr     = '0;
    bus.wr_re      = '0;
    bus.wr_im      = '0;
    bus.finish_FFT = 1'b0;
    bus.done_o     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic rd(input int ptr);
    bus.en_rd  = 1'b1;
    bus.rd_ptr = (SIZE+1)'(ptr);
  endtask

  task automatic wr(input int ptr, input logic [BW-1:0] re, input logic [BW-1:0] im);
    bus.en_wr  = 1'b1;
    bus.wr_ptr = (SIZE+1)'(ptr);
    bus.wr_re  = re;
    bus.wr_im  = im;
  endtask

  // Streams N samples; pattern 0: re=k, im=-k; pattern 1: re=3k+1, im=16k.
  task automatic load_all(input int pattern);
    logic [BW-1:0] re, im;
    for (int k = 0; k < N; k++) begin
      tick();
      re = (pattern == 0) ? BW'(k) : BW'(3 * k + 1);
      im = (pattern == 0) ? BW'(-k) : BW'(16 * k);
      bus.din_valid = 1'b1;
      bus.din_re    = re;
      bus.din_im    = im;
      mem_m[brev(k)] = {re, im};
      if (k == N - 1) rd(3);  // stale read alongside the final load write
      @(negedge clk);
      check("load_flag_low", OPW'(bus.flag_start_FFT), OPW'(0));
      check("load_din_ready", OPW'(bus.din_ready), OPW'(1));
    end
  endtask

  task automatic push_op(input int a, input int b, input int at);
    exp_op_q.push_back({mem_m[a], mem_m[b]});
    exp_op_cyc_q.push_back(at);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.op_valid === 1'b1) begin
        if (exp_op_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL op_unexpected: op_valid=1 at cycle %0d, required 0", cyc);
        end else begin
          check("op_data", {bus.op_a_re, bus.op_a_im, bus.op_b_re, bus.op_b_im}, exp_op_q.pop_front());
          check("op_cycle", OPW'(cyc), OPW'(exp_op_cyc_q.pop_front()));
        end
      end
      if (bus.dout_valid === 1'b1) begin
        if (exp_dout_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL dout_unexpected: dout_valid=1 at cycle %0d, required 0", cyc);
        end else begin
          check("dout_data", OPW'({bus.dout_re, bus.dout_im}), OPW'(exp_dout_q.pop_front()));
          check("dout_cycle", OPW'(cyc), OPW'(exp_dout_cyc_q.pop_front()));
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [DW-1:0] newv;
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_din_ready", OPW'(bus.din_ready), OPW'(1));
    check("rst_phase", OPW'(bus.phase), OPW'(0));
    check("rst_flag", OPW'(bus.flag_start_FFT), OPW'(0));
    check("rst_op_valid", OPW'(bus.op_valid), OPW'(0));
    check("rst_dout_valid", OPW'(bus.dout_valid), OPW'(0));
    check("rst_operands", {bus.op_a_re, bus.op_a_im, bus.op_b_re, bus.op_b_im}, OPW'(0));
    check("rst_dout", OPW'({bus.dout_re, bus.dout_im}), OPW'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Load and start.
    load_all(0);
    check("bitrev_ram1", OPW'(mem_m[1]), OPW'({BW'(8), BW'(-8)}));
    check("bitrev_ram3", OPW'(mem_m[3]), OPW'({BW'(12), BW'(-12)}));
    tick();
    bus.din_valid = 1'b1;  // dropped in COMPUTE
    bus.din_re    = BW'(32'h777);
    @(negedge clk);
    check("start_pulse", OPW'(bus.flag_start_FFT), OPW'(1));
    check("compute_din_ready", OPW'(bus.din_ready), OPW'(0));
    check("compute_phase", OPW'(bus.phase), OPW'(1));
    tick();
    @(negedge clk);
    check("start_single", OPW'(bus.flag_start_FFT), OPW'(0));

    // Two back-to-back pairs: (0,8) and (3,12).
    tick(); rd(0);
    tick(); rd(8);  push_op(0, 8, cyc + 1);
    tick(); rd(3);
    tick(); rd(12); push_op(3, 12, cyc + 1);
    tick();
    tick();
    @(negedge clk);
    check("op_valid_one_cycle", OPW'(bus.op_valid), OPW'(0));
    check("op_hold", {bus.op_a_re, bus.op_a_im, bus.op_b_re, bus.op_b_im}, {mem_m[3], mem_m[12]});

    // Same-cycle read/write of ptr 5, then re-read.
    tick(); wr(5, BW'(32'h123), BW'(32'h456)); rd(5);
    newv = {BW'(32'h123), BW'(32'h456)};
    tick(); rd(5);
    exp_op_q.push_back({mem_m[5], newv});
    exp_op_cyc_q.push_back(cyc + 1);
    mem_m[5] = newv;

    // Out-of-range write must not land anywhere.
    tick(); wr(16, BW'(32'h1ABCDEF), BW'(32'h0FEDCBA));

    // finish_FFT together with the second read still yields op_valid.
    tick(); rd(2);
    tick(); rd(6); bus.finish_FFT = 1'b1; push_op(2, 6, cyc + 1);
    tick();
    @(negedge clk);
    check("unload_phase", OPW'(bus.phase), OPW'(2));

    // Unload every entry, every other cycle.
    for (int i = 0; i < N; i++) begin
      tick(); rd(i);
      exp_dout_q.push_back(mem_m[i]);
      exp_dout_cyc_q.push_back(cyc + 1);
      tick();
    end
    tick(); rd(16);
    exp_dout_q.push_back('0);
    exp_dout_cyc_q.push_back(cyc + 1);
    tick();

    // Late write-back in UNLOAD lands.
    tick(); wr(7, BW'(32'h0AAAA), BW'(32'h15555));
    mem_m[7] = {BW'(32'h0AAAA), BW'(32'h15555)};
    tick(); rd(7);
    exp_dout_q.push_back(mem_m[7]);
    exp_dout_cyc_q.push_back(cyc + 1);
    tick();

    tick(); bus.done_o = 1'b1;
    tick();
    @(negedge clk);
    check("done_din_ready", OPW'(bus.din_ready), OPW'(1));
    check("done_phase", OPW'(bus.phase), OPW'(0));

    // Second load, then reset between the reads of a pair.
    load_all(1);
    tick();
    @(negedge clk);
    check("start_pulse_2", OPW'(bus.flag_start_FFT), OPW'(1));
    tick(); rd(4);
    tick(); rst_n = 1'b0;
    #1;
    check("midrst_phase", OPW'(bus.phase), OPW'(0));
    check("midrst_din_ready", OPW'(bus.din_ready), OPW'(1));
    check("midrst_op_valid", OPW'(bus.op_valid), OPW'(0));
    tick();
    rst_n = 1'b1;
    rd(12);  // would-be second read, must be ignored in LOAD
    repeat (4) tick();
    @(negedge clk);
    check("postrst_phase", OPW'(bus.phase), OPW'(0));
    check("postrst_op_valid", OPW'(bus.op_valid), OPW'(0));

    // Restart count after reset: exactly N samples trigger the start pulse.
    load_all(0);
    tick();
    @(negedge clk);
    check("start_pulse_3", OPW'(bus.flag_start_FFT), OPW'(1));
    repeat (2) tick();

    tests++;
    if (exp_op_q.size() != 0 || exp_dout_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d op and %0d dout expected outputs never seen, required 0",
               exp_op_q.size(), exp_dout_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
